// File: rtl/mossa_collector.sv
// Move collector in front of the Morra Cinese core: gathers one legal move per player, then presents the pair.
// Optional round timeout is compiled in with `define MOSSA_TIMEOUT_EN.
module mossa_collector #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inizia_in,
  input  logic [1:0] primo_mossa,
  input  logic       primo_valid,
  input  logic [1:0] secondo_mossa,
  input  logic       secondo_valid,
  input  logic       core_ready,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  output logic       mossa_valid,
  output logic       INIZIA,
  output logic       primo_ack,
  output logic       secondo_ack,
  output logic       illegal_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;

  generate
    if ((2 ** CNT_W) < TIMEOUT_CYCLES) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [1:0]      full_reg, full_next;
  logic [1:0][1:0] code_reg, code_next;
  logic [1:0]      primo_reg, primo_next;
  logic [1:0]      secondo_reg, secondo_next;
  logic            valid_reg, valid_next;
  logic            inizia_reg, inizia_next;
  logic [1:0]      ack_reg, ack_next;
  logic            illegal_reg, illegal_next;
  logic            timeout_hit;

  logic [1:0][1:0] mossa_in;
  logic [1:0]      valid_in;
  logic [1:0]      capture;
  logic [1:0]      illegal;

  assign mossa_in = {secondo_mossa, primo_mossa};
  assign valid_in = {secondo_valid, primo_valid};

  // A strobe into an already-full slot is ignored outright, even if its code is 00.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      logic open_slot;
      assign open_slot   = (state_reg == WAIT) && !inizia_in && valid_in[gi] && !full_reg[gi];
      assign capture[gi] = open_slot && (mossa_in[gi] != 2'b00);
      assign illegal[gi] = open_slot && (mossa_in[gi] == 2'b00);
    end
  endgenerate

`ifdef MOSSA_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg;

  assign timeout_hit = (state_reg == WAIT) && !inizia_in && (capture == 2'b00) &&
                       (full_reg[0] ^ full_reg[1]) &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg != WAIT || inizia_in || (capture != 2'b00) || timeout_hit)
      cnt_next = '0;
    else if (full_reg[0] ^ full_reg[1])
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_hit;
    end
  end

  assign timeout_err = timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    full_next    = full_reg;
    code_next    = code_reg;
    primo_next   = primo_reg;
    secondo_next = secondo_reg;
    valid_next   = valid_reg;
    inizia_next  = inizia_in;
    ack_next     = capture;
    illegal_next = |illegal;

    case (state_reg)
      IDLE: begin
        if (inizia_in) state_next = WAIT;
      end
      WAIT: begin
        if (inizia_in) begin
          full_next = 2'b00;
        end else if (full_reg == 2'b11) begin
          state_next   = PRESENT;
          valid_next   = 1'b1;
          primo_next   = code_reg[0];
          secondo_next = code_reg[1];
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (capture[i]) begin
              full_next[i] = 1'b1;
              code_next[i] = mossa_in[i];
            end
          end
          if (timeout_hit) full_next = 2'b00;
        end
      end
      PRESENT: begin
        // A transfer and a restart leave the same state behind, so they share one path.
        if ((valid_reg && core_ready) || inizia_in) begin
          state_next   = WAIT;
          full_next    = 2'b00;
          valid_next   = 1'b0;
          primo_next   = 2'b00;
          secondo_next = 2'b00;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      full_reg    <= 2'b00;
      code_reg    <= '0;
      primo_reg   <= 2'b00;
      secondo_reg <= 2'b00;
      valid_reg   <= 1'b0;
      inizia_reg  <= 1'b0;
      ack_reg     <= 2'b00;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      full_reg    <= full_next;
      code_reg    <= code_next;
      primo_reg   <= primo_next;
      secondo_reg <= secondo_next;
      valid_reg   <= valid_next;
      inizia_reg  <= inizia_next;
      ack_reg     <= ack_next;
      illegal_reg <= illegal_next;
    end
  end

  assign PRIMO       = primo_reg;
  assign SECONDO     = secondo_reg;
  assign mossa_valid = valid_reg;
  assign INIZIA      = inizia_reg;
  assign primo_ack   = ack_reg[0];
  assign secondo_ack = ack_reg[1];
  assign illegal_err = illegal_reg;

endmodule

// File: tb/tb_mossa_collector.sv
// Directed bench for mossa_collector: per-cycle vector table plus timeout and async-reset sequences.
module tb_mossa_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inizia_in;
  logic [1:0] primo_mossa;
  logic       primo_valid;
  logic [1:0] secondo_mossa;
  logic       secondo_valid;
  logic       core_ready;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic       mossa_valid;
  logic       INIZIA;
  logic       primo_ack;
  logic       secondo_ack;
  logic       illegal_err;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  mossa_collector #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .inizia_in(inizia_in),
    .primo_mossa(primo_mossa), .primo_valid(primo_valid),
    .secondo_mossa(secondo_mossa), .secondo_valid(secondo_valid),
    .core_ready(core_ready),
    .PRIMO(PRIMO), .SECONDO(SECONDO), .mossa_valid(mossa_valid), .INIZIA(INIZIA),
    .primo_ack(primo_ack), .secondo_ack(secondo_ack),
    .illegal_err(illegal_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Expected output word: {PRIMO, SECONDO, mossa_valid, INIZIA, primo_ack, secondo_ack, illegal_err, timeout_err}
  typedef struct {
    logic       ini;
    logic [1:0] pm;
    logic       pv;
    logic [1:0] sm;
    logic       sv;
    logic       rdy;
    logic [9:0] exp;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic ini, input logic [1:0] pm, input logic pv,
                              input logic [1:0] sm, input logic sv, input logic rdy,
                              input logic [1:0] p, input logic [1:0] s, input logic mv,
                              input logic in, input logic pa, input logic sa, input logic il);
    vec_t v;
    v.ini = ini; v.pm = pm; v.pv = pv; v.sm = sm; v.sv = sv; v.rdy = rdy;
    v.exp = {p, s, mv, in, pa, sa, il, 1'b0};
    return v;
  endfunction

  function automatic logic [9:0] obs();
    return {PRIMO, SECONDO, mossa_valid, INIZIA, primo_ack, secondo_ack, illegal_err, timeout_err};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end else begin
      $display("ok   %s outputs=%b", name, got);
    end
  endtask

  task automatic drive(input logic ini, input logic [1:0] pm, input logic pv,
                       input logic [1:0] sm, input logic sv, input logic rdy);
    @(negedge clk);
    inizia_in = ini; primo_mossa = pm; primo_valid = pv;
    secondo_mossa = sm; secondo_valid = sv; core_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    //               ini pm    pv  sm    sv  rdy  P      S      mv  IN  pa  sa  il
    vecs[0]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 2'b01, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 2'b01, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 2'b11, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 2'b00, 0, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    vecs[8]  = mk(0, 2'b00, 0, 2'b10, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 2'b10, 1, 0, 0, 0, 0);
    vecs[10] = mk(0, 2'b10, 1, 2'b00, 0, 0, 2'b01, 2'b10, 1, 0, 0, 0, 0);
    vecs[11] = mk(0, 2'b00, 0, 2'b11, 1, 0, 2'b01, 2'b10, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 2'b10, 1, 0, 0, 0, 0);
    vecs[13] = mk(0, 2'b00, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 2'b11, 1, 2'b11, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0);
    vecs[15] = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0, 0);
    vecs[16] = mk(1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 2'b10, 1, 2'b01, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0);
    vecs[18] = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 2'b01, 1, 0, 0, 0, 0);
    vecs[19] = mk(1, 2'b00, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    vecs[20] = mk(1, 2'b01, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    vecs[21] = mk(0, 2'b01, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    vecs[22] = mk(0, 2'b00, 0, 2'b11, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    vecs[23] = mk(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 2'b11, 1, 0, 0, 0, 0);
    vecs[24] = mk(0, 2'b00, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 2'b00, 1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);

    rst_n = 1'b0;
    inizia_in = 1'b0; primo_mossa = 2'b00; primo_valid = 1'b0;
    secondo_mossa = 2'b00; secondo_valid = 1'b0; core_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ini, vecs[i].pm, vecs[i].pv, vecs[i].sm, vecs[i].sv, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Partial round: only player 1 moves.
    drive(1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0);
    check("partial_ack", 10'b00_00_0_0_1_0_0_0);
`ifdef MOSSA_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      idle();
      check($sformatf("to_wait%0d", k), 10'b0);
    end
    idle();
    check("timeout_pulse", 10'b00_00_0_0_0_0_0_1);
    idle();
    check("timeout_single", 10'b0);
    drive(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    check("after_to_sack", 10'b00_00_0_0_0_1_0_0);
    idle();
    check("slot_cleared", 10'b0);
    drive(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
    check("after_to_pack", 10'b00_00_0_0_1_0_0_0);
    idle();
    check("after_to_pair", 10'b11_01_1_0_0_0_0_0);
`else
    for (int k = 1; k <= 20; k++) begin
      idle();
      check($sformatf("hold%0d", k), 10'b0);
    end
    drive(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    check("late_sack", 10'b00_00_0_0_0_1_0_0);
    idle();
    check("late_pair", 10'b10_01_1_0_0_0_0_0);
`endif
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    check("late_xfer", 10'b0);

    // Asynchronous reset in PRESENT drops the pair without waiting for a clock edge.
    drive(1'b0, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0);
    check("rst_round_acks", 10'b00_00_0_0_1_1_0_0);
    idle();
    check("rst_round_pair", 10'b01_10_1_0_0_0_0_0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0);
    check("post_reset_idle", 10'b0);
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    check("post_reset_start", 10'b00_00_0_1_0_0_0_0);
    drive(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
    check("post_reset_pack", 10'b00_00_0_0_1_0_0_0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mossa_collector.md
Name: mossa_collector

Overview:
- Input stage directly upstream of the Morra Cinese game core.
- Collects one move from each player through independent valid/ack strobes and rejects illegal codes.
- Once both moves are held, presents them as a single stable pair with a valid/ready handshake.
- Also generates the core's one-cycle INIZIA start pulse, and can optionally time out a round that is left incomplete.

Parameters:
TIMEOUT_CYCLES, 1000, WAIT cycles allowed before a partial round is discarded (only with MOSSA_TIMEOUT_EN)
CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W >= TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inizia_in  input  1  start/restart request, one-cycle pulse
primo_mossa  input  2  player 1 move: 01 sasso, 10 carta, 11 forbice, 00 illegal
primo_valid  input  1  player 1 move strobe
secondo_mossa  input  2  player 2 move, same encoding
secondo_valid  input  1  player 2 move strobe
core_ready  input  1  game core accepts the presented pair
PRIMO  output  2  registered player 1 move to the core
SECONDO  output  2  registered player 2 move to the core
mossa_valid  output  1  PRIMO/SECONDO pair valid
INIZIA  output  1  one-cycle start pulse to the core
primo_ack  output  1  one-cycle acknowledge of a captured player 1 move
secondo_ack  output  1  one-cycle acknowledge of a captured player 2 move
illegal_err  output  1  one-cycle pulse: a valid strobe carried code 00
timeout_err  output  1  one-cycle pulse: a partial round was discarded

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state = IDLE;
  - PRIMO = SECONDO = 00;
  - all 1-bit outputs = 0;
  - both slot-full flags = 0;
  - timeout counter = 0.
- Asserting rst_n mid-round discards all held moves immediately.

States:
- IDLE:
  - Ignore all move strobes; no acks are issued.
  - On inizia_in: INIZIA = 1 on the next cycle and go to WAIT.
- WAIT, per player, independently:
  - valid with a non-00 code and empty slot: capture the code, set the slot full, and pulse ack on the next cycle.
  - valid with code 00: illegal_err pulses next cycle; nothing is captured and no ack is given.
  - valid while the slot is already full: ignored; no ack and no error.
  - Both players strobing in the same cycle: both moves are captured and both acks pulse together.
  - When both slots are full, enter PRESENT on the next cycle.
- PRESENT:
  - mossa_valid = 1; PRIMO/SECONDO hold the captured codes, stable until transfer.
  - Transfer = mossa_valid & core_ready at a rising edge.
  - On transfer: clear both slots, set mossa_valid = 0 and PRIMO/SECONDO = 00 on the next cycle, return to WAIT.
  - Move strobes arriving in PRESENT are ignored (no ack, no error).

Restart and priority:
- inizia_in in WAIT or PRESENT:
  - Clear both slots and the counter, drop mossa_valid, pulse INIZIA next cycle, go to WAIT.
  - This is an abort of the round in progress.
- inizia_in and a transfer in the same cycle: the transfer counts as completed, then the restart applies.
- inizia_in has priority over a move capture in the same cycle; that move is dropped with no ack.
- INIZIA is never high for 2 consecutive cycles unless inizia_in is.

Optional Feature:
MOSSA_TIMEOUT_EN
- Defined:
  - The counter is cleared on entry to WAIT and on every capture, and increments each WAIT cycle in which exactly one slot is full.
  - At count == TIMEOUT_CYCLES-1: timeout_err pulses next cycle, both slots clear, the counter resets, and the block stays in WAIT.
- Undefined:
  - No counter is instantiated; timeout_err is tied to 0.
  - WAIT holds a partial round indefinitely.

Test Plan:
- Reset, inizia_in pulse at cycle 2 -> INIZIA = 1 at cycle 3 only, state WAIT; all other outputs 0.
- primo 01 at cycle 5, secondo 10 at cycle 8 -> primo_ack at 6, secondo_ack at 9; mossa_valid = 1 at 10 with PRIMO = 01, SECONDO = 10.
- core_ready held low for 4 cycles in PRESENT -> pair stays stable.
- core_ready high -> mossa_valid = 0 next cycle, outputs return to 00.
- Both valid in the same cycle (11, 11) -> both acks in the same cycle; mossa_valid follows 1 cycle later.
- primo_valid with code 00 -> illegal_err pulse, no ack; a repeat primo strobe while the slot is full -> no ack, no error.
- MOSSA_TIMEOUT_EN, TIMEOUT_CYCLES = 8, only primo moves -> timeout_err 8 cycles after capture and the slot cleared.
- inizia_in during PRESENT -> mossa_valid drops, INIZIA pulses, a fresh round is accepted.
